sine_playback_ctrl: RTL and testbench
=====================================

# sine_playback_ctrl

Playback controller for the RAM_SENO sine-table RAM. Holds a phase accumulator and, on each sample-rate tick, fetches one table entry and presents it on a valid/ready sample stream. Shares the RAM's single port with the host write path, which the AXI4-Lite register block drives. It sits between the AXI4-Lite slave, the table RAM and the downstream DAC/PWM sample consumer.

## Interface
Parameters:
- ADDR_W, 8: table address width; the table holds 2^ADDR_W entries.
- DATA_W, 32: sample and table word width.
- PHASE_W, 24: phase accumulator width; must be ≥ ADDR_W.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- cfg_enable  in  1  playback enable.
- cfg_phase_inc  in  PHASE_W  phase step per tick.
- cfg_clr_overrun  in  1  one-cycle pulse that clears sticky overrun.
- sample_tick  in  1  one-cycle sample-rate strobe.
- host_wr_valid  in  1  host write request.
- host_wr_addr  in  ADDR_W  host write address.
- host_wr_data  in  DATA_W  host write data.
- host_wr_ready  out  1  host write accepted this cycle.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid 1 cycle after a read.
- smp_valid  out  1  sample available.
- smp_data  out  DATA_W  sample value.
- smp_ready  in  1  consumer accepts sample.
- overrun  out  1  sticky: a tick arrived while the controller was busy.
- phase  out  PHASE_W  current accumulator value.

## Operation
- Reset: state IDLE. All outputs are 0, including phase, smp_data and overrun.
- FSM states and transitions:
  - IDLE: go to WAIT_TICK when cfg_enable=1.
  - WAIT_TICK: go to READ on sample_tick.
  - READ: issue the table read, or defer it for one host write (see Arbitration).
  - CAPTURE: always go to HOLD next cycle.
  - HOLD: go to WAIT_TICK on smp_ready.
- Leaving playback: cfg_enable=0 in any state forces IDLE on the next edge. smp_valid clears and phase returns to 0. A RAM read in flight is discarded.
- Read address: the read in READ uses ram_addr = phase[PHASE_W-1 -: ADDR_W].
- CAPTURE: smp_data <= ram_rdata. phase <= phase + cfg_phase_inc, modulo 2^PHASE_W (wraps silently, no carry kept).
- HOLD: smp_valid=1 and smp_data stays stable until the smp_valid && smp_ready handshake.
- Arbitration for the RAM port:
  - In every state except READ and CAPTURE, a host write passes straight through: host_wr_ready=1, ram_en=ram_we=host_wr_valid, and address/data are forwarded.
  - In READ without a prior deferral, host_wr_valid=1 wins. The host write is performed, the internal deferred flag is set, and the FSM stays in READ.
  - In READ with deferred=1, playback wins: host_wr_ready=0 and the read is issued. deferred clears on leaving READ.
  - In CAPTURE, host_wr_ready=0 so the captured read data is protected.
- Overrun:
  - overrun sets when sample_tick=1 while cfg_enable=1 and state ≠ WAIT_TICK. That tick is dropped.
  - cfg_clr_overrun clears overrun. If set and clear occur in the same cycle, set wins.
  - A tick in IDLE, or while cfg_enable=0, is ignored and does not flag overrun.
- cfg_phase_inc=0: the same address repeats each tick; this is legal.

## Timing
- Tick to sample, no contention: tick sampled at edge N puts the FSM in READ (read issued in cycle N+1), CAPTURE at N+2, and smp_valid=1 from N+3.
- With one host deferral, smp_valid rises one cycle later. No deferral is ever longer than one cycle.
- Host write latency is 0 cycles when host_wr_ready=1 (combinational pass-through). Worst-case wait is 2 cycles: one deferred-READ cycle plus CAPTURE.
- Registered outputs: smp_valid, smp_data, overrun, phase.
- Combinational outputs: ram_* and host_wr_ready, derived from state, deferred and the host inputs.
- Reset mid-operation returns everything to the reset values immediately (asynchronous assert). Release of ARESETN is synchronous to ACLK.

## Structure
- Package sine_pkg holds:
  - the state enum (IDLE, WAIT_TICK, READ, CAPTURE, HOLD);
  - default width constants for ADDR_W, DATA_W and PHASE_W.
- Sub-module sine_phase_acc is the accumulator register with clear and step-enable inputs. It outputs phase and the table index.
- The top level contains the FSM, the arbitration mux, the sample register and the overrun flag.

## Test plan
- Basic playback: inc=0x010000, table[i]=i, four ticks 20 cycles apart → samples 0,1,2,3, each appearing 3 cycles after its tick. phase=0x040000 afterwards.
- Wrap-around: phase at 0xFF0000, inc=0x020000 → sample table[0xFF], then table[0x01]. Phase wraps to 0x010000.
- Host contention: host_wr_valid is held during READ → exactly one write is accepted in READ. Then host_wr_ready=0 for 2 cycles, and the sample arrives 4 cycles after the tick.
- Write-then-read coherency: host writes 0xDEADBEEF to the current index in the deferred cycle → the captured sample is 0xDEADBEEF.
- Backpressure and overrun: smp_ready=0 while a second tick arrives → overrun=1 and the sample is held unchanged. A simultaneous tick and cfg_clr_overrun keeps overrun=1; a lone clear gives overrun=0.
- Disable and reset mid-read: cfg_enable dropped in CAPTURE → IDLE next cycle with smp_valid=0 and phase=0. ARESETN low in HOLD → all outputs are 0 immediately.

Source files
------------

// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared state encoding and default widths for sine table playback
package sine_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_PHASE_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    READ,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/sine_phase_acc.sv
// rtl/sine_phase_acc.sv - phase accumulator; top ADDR_W bits form the table index
module sine_phase_acc
  import sine_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_step,
  input  logic [PHASE_W-1:0] i_inc,
  output logic [PHASE_W-1:0] o_phase,
  output logic [ADDR_W-1:0]  o_index
);

  logic [PHASE_W-1:0] r_phase;

  // Sum is truncated to PHASE_W, so the accumulator wraps with no carry kept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (i_clr) begin
      r_phase <= '0;
    end else if (i_step) begin
      r_phase <= r_phase + i_inc;
    end
  end

  assign o_phase = r_phase;
  assign o_index = r_phase[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/sine_playback_ctrl.sv
// rtl/sine_playback_ctrl.sv - tick-driven sine table fetch sharing one RAM port with host writes
module sine_playback_ctrl
  import sine_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cfg_enable,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic               cfg_clr_overrun,
  input  logic               sample_tick,
  input  logic               host_wr_valid,
  input  logic [ADDR_W-1:0]  host_wr_addr,
  input  logic [DATA_W-1:0]  host_wr_data,
  output logic               host_wr_ready,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic               smp_valid,
  output logic [DATA_W-1:0]  smp_data,
  input  logic               smp_ready,
  output logic               overrun,
  output logic [PHASE_W-1:0] phase
);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_deferred;
  logic               w_defer_set;
  logic               r_smp_valid;
  logic [DATA_W-1:0]  r_smp_data;
  logic               r_overrun;
  logic [ADDR_W-1:0]  w_index;
  logic [PHASE_W-1:0] w_phase;

  sine_phase_acc #(
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W)
  ) u_phase_acc (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_clr   (!cfg_enable),
    .i_step  (cfg_enable && (r_state == CAPTURE)),
    .i_inc   (cfg_phase_inc),
    .o_phase (w_phase),
    .o_index (w_index)
  );

  always_comb begin
    w_state_next  = r_state;
    w_defer_set   = 1'b0;
    host_wr_ready = 1'b1;
    ram_en        = host_wr_valid;
    ram_we        = host_wr_valid;
    ram_addr      = host_wr_addr;
    ram_wdata     = host_wr_data;
    case (r_state)
      IDLE:      if (cfg_enable) w_state_next = WAIT_TICK;
      WAIT_TICK: if (sample_tick) w_state_next = READ;
      READ: begin
        // The host gets at most one cycle of priority per fetch.
        if (!r_deferred && host_wr_valid) begin
          w_defer_set = 1'b1;
        end else begin
          host_wr_ready = 1'b0;
          ram_en        = 1'b1;
          ram_we        = 1'b0;
          ram_addr      = w_index;
          ram_wdata     = '0;
          w_state_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        host_wr_ready = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        w_state_next  = HOLD;
      end
      HOLD:      if (smp_ready) w_state_next = WAIT_TICK;
      default:   w_state_next = IDLE;
    endcase
    if (!cfg_enable) w_state_next = IDLE;
    // Hold the shared port quiet while reset is asserted.
    if (!ARESETN) begin
      host_wr_ready = 1'b0;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_addr      = '0;
      ram_wdata     = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_deferred  <= 1'b0;
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_deferred <= w_defer_set && cfg_enable;
      if (!cfg_enable) begin
        r_smp_valid <= 1'b0;
      end else if (r_state == CAPTURE) begin
        r_smp_valid <= 1'b1;
        r_smp_data  <= ram_rdata;
      end else if ((r_state == HOLD) && smp_ready) begin
        r_smp_valid <= 1'b0;
      end
      if (sample_tick && cfg_enable && (r_state != WAIT_TICK) && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end else if (cfg_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign smp_valid = r_smp_valid;
  assign smp_data  = r_smp_data;
  assign overrun   = r_overrun;
  assign phase     = w_phase;

endmodule

// File: tb/tb_sine_playback_ctrl.sv
// tb/tb_sine_playback_ctrl.sv - directed checks of playback, arbitration, overrun and reset
module tb_sine_playback_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cfg_enable;
  logic [23:0] cfg_phase_inc;
  logic        cfg_clr_overrun;
  logic        sample_tick;
  logic        host_wr_valid;
  logic [7:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        host_wr_ready;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        smp_valid;
  logic [31:0] smp_data;
  logic        smp_ready;
  logic        overrun;
  logic [23:0] phase;

  logic [31:0] mem [256];
  int n_pass;
  int n_checks;

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  sine_playback_ctrl dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .cfg_enable      (cfg_enable),
    .cfg_phase_inc   (cfg_phase_inc),
    .cfg_clr_overrun (cfg_clr_overrun),
    .sample_tick     (sample_tick),
    .host_wr_valid   (host_wr_valid),
    .host_wr_addr    (host_wr_addr),
    .host_wr_data    (host_wr_data),
    .host_wr_ready   (host_wr_ready),
    .ram_en          (ram_en),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .smp_valid       (smp_valid),
    .smp_data        (smp_data),
    .smp_ready       (smp_ready),
    .overrun         (overrun),
    .phase           (phase)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Drive a one-cycle tick from WAIT_TICK and advance to the HOLD state.
  task automatic tick_once();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    host_wr_valid = 1'b1;
    host_wr_addr  = 8'h55;
    host_wr_data  = 32'hA5A5A5A5;
    #3;
    n_checks++; if (phase !== 24'h0) $display("FAIL reset_phase: got %h want 0", phase); else n_pass++;
    n_checks++; if (smp_valid !== 1'b0) $display("FAIL reset_smp_valid: got %b want 0", smp_valid); else n_pass++;
    n_checks++; if (smp_data !== 32'h0) $display("FAIL reset_smp_data: got %h want 0", smp_data); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    n_checks++; if (host_wr_ready !== 1'b0) $display("FAIL reset_host_ready: got %b want 0", host_wr_ready); else n_pass++;
    n_checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) $display("FAIL reset_ram_en_we: got %b%b want 00", ram_en, ram_we); else n_pass++;
    host_wr_valid = 1'b0;
    step();
    ARESETN = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 8'(i);
      host_wr_data  = 32'(i);
      step();
    end
    host_wr_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    host_wr_valid = 1'b1;
    host_wr_addr  = 8'h90;
    host_wr_data  = 32'h0000_0090;
    #1;
    n_checks++; if (host_wr_ready !== 1'b1) $display("FAIL idle_host_ready: got %b want 1", host_wr_ready); else n_pass++;
    n_checks++; if (ram_en !== 1'b1 || ram_we !== 1'b1) $display("FAIL idle_ram_en_we: got %b%b want 11", ram_en, ram_we); else n_pass++;
    n_checks++; if (ram_addr !== 8'h90 || ram_wdata !== 32'h90) $display("FAIL idle_ram_fwd: got %h/%h want 90/90", ram_addr, ram_wdata); else n_pass++;
    step();
    host_wr_valid = 1'b0;
  endtask

  task automatic test_basic_playback();
    cfg_phase_inc = 24'h010000;
    smp_ready     = 1'b1;
    cfg_enable    = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      n_checks++; if (smp_valid !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %b want 0", k, smp_valid); else n_pass++;
      step();
      n_checks++; if (smp_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", k, smp_valid); else n_pass++;
      n_checks++; if (smp_data !== 32'(k)) $display("FAIL basic_data[%0d]: got %h want %h", k, smp_data, 32'(k)); else n_pass++;
      n_checks++; if (phase !== 24'((k + 1) << 16)) $display("FAIL basic_phase[%0d]: got %h want %h", k, phase, 24'((k + 1) << 16)); else n_pass++;
      repeat (17) step();
    end
    n_checks++; if (phase !== 24'h040000) $display("FAIL basic_final_phase: got %h want 040000", phase); else n_pass++;
  endtask

  task automatic test_wrap_around();
    cfg_enable = 1'b0;
    step();
    n_checks++; if (phase !== 24'h0) $display("FAIL wrap_clear_phase: got %h want 0", phase); else n_pass++;
    cfg_enable    = 1'b1;
    cfg_phase_inc = 24'hFF0000;
    step();
    tick_once();
    n_checks++; if (phase !== 24'hFF0000) $display("FAIL wrap_setup_phase: got %h want FF0000", phase); else n_pass++;
    step();
    cfg_phase_inc = 24'h020000;
    tick_once();
    n_checks++; if (smp_data !== 32'hFF) $display("FAIL wrap_data_ff: got %h want ff", smp_data); else n_pass++;
    n_checks++; if (phase !== 24'h010000) $display("FAIL wrap_phase: got %h want 010000", phase); else n_pass++;
    step();
    tick_once();
    n_checks++; if (smp_data !== 32'h01) $display("FAIL wrap_data_01: got %h want 01", smp_data); else n_pass++;
    n_checks++; if (phase !== 24'h030000) $display("FAIL wrap_phase2: got %h want 030000", phase); else n_pass++;
    step();
  endtask

  task automatic test_host_contention();
    cfg_phase_inc = 24'h010000;
    sample_tick = 1'b1;
    step();
    sample_tick   = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_addr  = 8'h80;
    host_wr_data  = 32'h1234_5678;
    #1;
    n_checks++; if (host_wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h80) $display("FAIL cont_first_write: got rdy=%b we=%b a=%h want 1 1 80", host_wr_ready, ram_we, ram_addr); else n_pass++;
    step();
    n_checks++; if (host_wr_ready !== 1'b0) $display("FAIL cont_defer_ready: got %b want 0", host_wr_ready); else n_pass++;
    n_checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h03) $display("FAIL cont_read_issue: got en=%b we=%b a=%h want 1 0 03", ram_en, ram_we, ram_addr); else n_pass++;
    step();
    n_checks++; if (host_wr_ready !== 1'b0 || ram_en !== 1'b0) $display("FAIL cont_capture_block: got rdy=%b en=%b want 0 0", host_wr_ready, ram_en); else n_pass++;
    n_checks++; if (smp_valid !== 1'b0) $display("FAIL cont_early_valid: got %b want 0", smp_valid); else n_pass++;
    step();
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h3) $display("FAIL cont_sample: got v=%b d=%h want 1 3", smp_valid, smp_data); else n_pass++;
    n_checks++; if (mem[8'h80] !== 32'h1234_5678) $display("FAIL cont_host_mem: got %h want 12345678", mem[8'h80]); else n_pass++;
    host_wr_valid = 1'b0;
    step();
  endtask

  task automatic test_write_then_read();
    sample_tick = 1'b1;
    step();
    sample_tick   = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_addr  = 8'h04;
    host_wr_data  = 32'hDEADBEEF;
    #1;
    n_checks++; if (host_wr_ready !== 1'b1) $display("FAIL coh_host_ready: got %b want 1", host_wr_ready); else n_pass++;
    step();
    host_wr_valid = 1'b0;
    step();
    step();
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 32'hDEADBEEF) $display("FAIL coh_sample: got v=%b d=%h want 1 deadbeef", smp_valid, smp_data); else n_pass++;
    step();
  endtask

  task automatic test_backpressure_overrun();
    smp_ready = 1'b0;
    tick_once();
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h5) $display("FAIL bp_first: got v=%b d=%h want 1 5", smp_valid, smp_data); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL bp_no_overrun: got %b want 0", overrun); else n_pass++;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun_set: got %b want 1", overrun); else n_pass++;
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h5) $display("FAIL bp_held: got v=%b d=%h want 1 5", smp_valid, smp_data); else n_pass++;
    n_checks++; if (phase !== 24'h060000) $display("FAIL bp_phase: got %h want 060000", phase); else n_pass++;
    sample_tick     = 1'b1;
    cfg_clr_overrun = 1'b1;
    step();
    sample_tick = 1'b0;
    n_checks++; if (overrun !== 1'b1) $display("FAIL bp_set_beats_clr: got %b want 1", overrun); else n_pass++;
    step();
    cfg_clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) $display("FAIL bp_clr: got %b want 0", overrun); else n_pass++;
    smp_ready = 1'b1;
    step();
    n_checks++; if (smp_valid !== 1'b0) $display("FAIL bp_handshake: got %b want 0", smp_valid); else n_pass++;
  endtask

  task automatic test_disable_mid_read();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    cfg_enable = 1'b0;
    step();
    n_checks++; if (smp_valid !== 1'b0) $display("FAIL dis_valid: got %b want 0", smp_valid); else n_pass++;
    n_checks++; if (phase !== 24'h0) $display("FAIL dis_phase: got %h want 0", phase); else n_pass++;
    n_checks++; if (smp_data !== 32'h5) $display("FAIL dis_data_kept: got %h want 5", smp_data); else n_pass++;
    n_checks++; if (host_wr_ready !== 1'b1) $display("FAIL dis_idle_ready: got %b want 1", host_wr_ready); else n_pass++;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    n_checks++; if (overrun !== 1'b0 || smp_valid !== 1'b0) $display("FAIL dis_tick_ignored: got ov=%b v=%b want 0 0", overrun, smp_valid); else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    cfg_phase_inc = 24'h070000;
    smp_ready     = 1'b1;
    cfg_enable    = 1'b1;
    step();
    tick_once();
    step();
    smp_ready = 1'b0;
    tick_once();
    n_checks++; if (smp_valid !== 1'b1 || smp_data !== 32'h7 || phase !== 24'h0E0000) $display("FAIL rst_setup: got v=%b d=%h p=%h want 1 7 0e0000", smp_valid, smp_data, phase); else n_pass++;
    sample_tick = 1'b1;
    step();
    sample_tick   = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_addr  = 8'h33;
    host_wr_data  = 32'h3333_3333;
    #2;
    ARESETN = 1'b0;
    #1;
    n_checks++; if (smp_valid !== 1'b0 || smp_data !== 32'h0) $display("FAIL rst_hold_sample: got v=%b d=%h want 0 0", smp_valid, smp_data); else n_pass++;
    n_checks++; if (overrun !== 1'b0 || phase !== 24'h0) $display("FAIL rst_hold_ov_phase: got ov=%b p=%h want 0 0", overrun, phase); else n_pass++;
    n_checks++; if (host_wr_ready !== 1'b0 || ram_en !== 1'b0 || ram_we !== 1'b0) $display("FAIL rst_hold_port: got rdy=%b en=%b we=%b want 0 0 0", host_wr_ready, ram_en, ram_we); else n_pass++;
    host_wr_valid = 1'b0;
    step();
    ARESETN = 1'b1;
    step();
  endtask

  initial begin
    n_pass          = 0;
    n_checks        = 0;
    ARESETN         = 1'b0;
    cfg_enable      = 1'b0;
    cfg_phase_inc   = '0;
    cfg_clr_overrun = 1'b0;
    sample_tick     = 1'b0;
    host_wr_valid   = 1'b0;
    host_wr_addr    = '0;
    host_wr_data    = '0;
    smp_ready       = 1'b0;
    test_reset();
    test_passthrough();
    test_basic_playback();
    test_wrap_around();
    test_host_contention();
    test_write_then_read();
    test_backpressure_overrun();
    test_disable_mid_read();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
